mem_perf_counters: RTL and testbench
====================================

Name: mem_perf_counters

Overview:
- Memory-side performance counter unit that drives the mem_* and dcache_prefetch_requests fields of the memory-system perf interface (master side).
- Snoops the cluster-to-memory request/response handshakes.
- Counts reads, writes, stalls and prefetch issues.
- Accumulates total read latency by integrating the number of outstanding reads every cycle.
- All outputs are registered. The block is a pure observer and never back-pressures the memory path.

Parameters:
- CTR_BITS, 44, width of every exported counter (matches the perf counter width).
- PENDING_BITS, 8, width of the outstanding-read tracker.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- perf_clear  input  1  synchronous clear of all counters and the error flag (pending tracker is kept)
- mem_req_valid  input  1  memory request valid
- mem_req_ready  input  1  memory request ready
- mem_req_rw  input  1  request type, 1 = write, 0 = read
- mem_req_prefetch  input  1  request was issued by the dcache prefetcher
- mem_rsp_valid  input  1  memory response valid (read data only)
- mem_rsp_ready  input  1  memory response ready
- mem_reads  output  CTR_BITS  read requests accepted
- mem_writes  output  CTR_BITS  write requests accepted
- mem_stalls  output  CTR_BITS  cycles with request valid and not ready
- mem_latency  output  CTR_BITS  sum over cycles of outstanding reads
- dcache_prefetch_requests  output  CTR_BITS  accepted requests with mem_req_prefetch=1
- pending_reads  output  PENDING_BITS  current outstanding-read count
- perf_err  output  1  sticky flag: response with no pending read, or pending overflow

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-high, named reset. On reset, all outputs are 0.
- Event decodes:
  - req_fire = mem_req_valid & mem_req_ready
  - rsp_fire = mem_rsp_valid & mem_rsp_ready
  - rd_fire = req_fire & ~mem_req_rw
- Counters, each updated on the clock edge following the event cycle (1-cycle latency to outputs):
  - mem_reads += rd_fire.
  - mem_writes += req_fire & mem_req_rw.
  - mem_stalls += mem_req_valid & ~mem_req_ready.
  - dcache_prefetch_requests += req_fire & mem_req_prefetch. This counts both read and write prefetch, although prefetches are reads in practice.
- Pending tracker:
  - pending_reads_next = pending_reads + rd_fire - rsp_fire.
  - Simultaneous rd_fire and rsp_fire leaves the count unchanged.
- Latency integration:
  - Each cycle, mem_latency += pending_reads, using the registered value at cycle start and zero-extended to CTR_BITS.
  - A read accepted in cycle t and answered in cycle t+L contributes exactly L.
  - A same-cycle request and response between two different reads has no double count.
- Underflow: rsp_fire with pending_reads==0 and no rd_fire holds pending at 0 and sets perf_err.
- Overflow: rd_fire without rsp_fire at pending_reads==2^PENDING_BITS-1 saturates the count and sets perf_err.
- Counter width: all counters wrap modulo 2^CTR_BITS with no saturation.
- perf_clear:
  - Zeroes the five counters and perf_err on the next edge; events in the clear cycle are discarded.
  - pending_reads keeps tracking, so in-flight reads are not lost.
  - Reset overrides perf_clear.
- Reset mid-operation: all state returns to 0 on the next edge. Responses arriving afterwards for pre-reset reads trigger the underflow rule; the environment must drain memory across reset.
- No state machine beyond the tracker. No combinational path from inputs to outputs.

Test Plan:
- Reset then idle 10 cycles -> all outputs 0, perf_err 0.
- Single read accepted at cycle 5, response at cycle 9 -> mem_reads=1, pending_reads=1 during cycles 6..9 and 0 from cycle 10, mem_latency=4, perf_err 0.
- Three back-to-back reads (cycles 0,1,2), responses at cycles 10,11,12 -> mem_reads=3, mem_latency=30, peak pending_reads=3.
- Write and prefetch handling: write accepted, then prefetch read accepted, then mem_req_valid=1 with ready=0 for 4 cycles -> mem_writes=1, mem_reads=1, dcache_prefetch_requests=1, mem_stalls=4.
- Read fire and response fire in the same cycle while pending_reads=2 -> pending_reads stays 2. A response with pending_reads=0 -> pending stays 0 and perf_err=1.
- perf_clear asserted with mem_latency=30 and pending_reads=1 -> next cycle counters 0 and perf_err 0. The eventual response at 5 cycles after issue adds only post-clear cycles to mem_latency.

Source files
------------

// File: rtl/mem_perf_counters.sv
// rtl/mem_perf_counters.sv - memory-side perf counters: reads, writes, stalls, prefetches, read latency
module mem_perf_counters #(
  parameter int CTR_BITS     = 44,
  parameter int PENDING_BITS = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    perf_clear,
  input  logic                    mem_req_valid,
  input  logic                    mem_req_ready,
  input  logic                    mem_req_rw,
  input  logic                    mem_req_prefetch,
  input  logic                    mem_rsp_valid,
  input  logic                    mem_rsp_ready,
  output logic [CTR_BITS-1:0]     mem_reads,
  output logic [CTR_BITS-1:0]     mem_writes,
  output logic [CTR_BITS-1:0]     mem_stalls,
  output logic [CTR_BITS-1:0]     mem_latency,
  output logic [CTR_BITS-1:0]     dcache_prefetch_requests,
  output logic [PENDING_BITS-1:0] pending_reads,
  output logic                    perf_err
);

  localparam logic [PENDING_BITS-1:0] PEND_MAX = '1;

  logic req_fire, rsp_fire, rd_fire, wr_fire, pf_fire, stall;
  logic err_set;

  logic [CTR_BITS-1:0]     reads_q, reads_d;
  logic [CTR_BITS-1:0]     writes_q, writes_d;
  logic [CTR_BITS-1:0]     stalls_q, stalls_d;
  logic [CTR_BITS-1:0]     latency_q, latency_d;
  logic [CTR_BITS-1:0]     prefetch_q, prefetch_d;
  logic [PENDING_BITS-1:0] pending_q, pending_d;
  logic                    err_q, err_d;

  assign req_fire = mem_req_valid & mem_req_ready;
  assign rsp_fire = mem_rsp_valid & mem_rsp_ready;
  assign rd_fire  = req_fire & ~mem_req_rw;
  assign wr_fire  = req_fire & mem_req_rw;
  assign pf_fire  = req_fire & mem_req_prefetch;
  assign stall    = mem_req_valid & ~mem_req_ready;

  // Tracker saturates at both ends; a simultaneous issue and retire cancels out.
  always_comb begin
    pending_d = pending_q;
    err_set   = 1'b0;
    if (rd_fire && !rsp_fire) begin
      if (pending_q == PEND_MAX) err_set = 1'b1;
      else                       pending_d = pending_q + 1'b1;
    end else if (rsp_fire && !rd_fire) begin
      if (pending_q == '0) err_set = 1'b1;
      else                 pending_d = pending_q - 1'b1;
    end
  end

  // Clear discards this cycle's events for the counters but not for the tracker.
  always_comb begin
    reads_d    = reads_q + CTR_BITS'(rd_fire);
    writes_d   = writes_q + CTR_BITS'(wr_fire);
    stalls_d   = stalls_q + CTR_BITS'(stall);
    prefetch_d = prefetch_q + CTR_BITS'(pf_fire);
    latency_d  = latency_q + CTR_BITS'(pending_q);
    err_d      = err_q | err_set;
    if (perf_clear) begin
      reads_d    = '0;
      writes_d   = '0;
      stalls_d   = '0;
      prefetch_d = '0;
      latency_d  = '0;
      err_d      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reads_q    <= '0;
      writes_q   <= '0;
      stalls_q   <= '0;
      prefetch_q <= '0;
      latency_q  <= '0;
      pending_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      reads_q    <= reads_d;
      writes_q   <= writes_d;
      stalls_q   <= stalls_d;
      prefetch_q <= prefetch_d;
      latency_q  <= latency_d;
      pending_q  <= pending_d;
      err_q      <= err_d;
    end
  end

  assign mem_reads                = reads_q;
  assign mem_writes               = writes_q;
  assign mem_stalls               = stalls_q;
  assign mem_latency              = latency_q;
  assign dcache_prefetch_requests = prefetch_q;
  assign pending_reads            = pending_q;
  assign perf_err                 = err_q;

endmodule

// File: tb/tb_mem_perf_counters.sv
// tb/tb_mem_perf_counters.sv - bench for mem_perf_counters: directed plan plus randomized model run
module tb_mem_perf_counters;

  localparam int CTR_BITS     = 44;
  localparam int PENDING_BITS = 8;
  localparam longint MASK     = (longint'(1) << CTR_BITS) - 1;
  localparam int PEND_LIMIT   = (1 << PENDING_BITS) - 1;

  logic clk = 1'b0;
  logic reset, perf_clear;
  logic mem_req_valid, mem_req_ready, mem_req_rw, mem_req_prefetch;
  logic mem_rsp_valid, mem_rsp_ready;
  logic [CTR_BITS-1:0]     mem_reads, mem_writes, mem_stalls, mem_latency, dcache_prefetch_requests;
  logic [PENDING_BITS-1:0] pending_reads;
  logic                    perf_err;

  int checks = 0;
  int errors = 0;

  longint m_reads, m_writes, m_stalls, m_lat, m_pf;
  int     m_pend;
  bit     m_err;

  mem_perf_counters #(.CTR_BITS(CTR_BITS), .PENDING_BITS(PENDING_BITS)) dut (
    .clk(clk), .reset(reset), .perf_clear(perf_clear),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_rw(mem_req_rw), .mem_req_prefetch(mem_req_prefetch),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready),
    .mem_reads(mem_reads), .mem_writes(mem_writes), .mem_stalls(mem_stalls),
    .mem_latency(mem_latency), .dcache_prefetch_requests(dcache_prefetch_requests),
    .pending_reads(pending_reads), .perf_err(perf_err)
  );

  always #5 clk = ~clk;

  // Reference: counters are plain event tallies, latency is the running sum of outstanding reads.
  task automatic model_step();
    bit req, rsp, rd;
    int pend_next;
    bit bad;
    req = mem_req_valid && mem_req_ready;
    rsp = mem_rsp_valid && mem_rsp_ready;
    rd  = req && !mem_req_rw;
    bad = 1'b0;
    pend_next = m_pend + int'(rd) - int'(rsp);
    if (pend_next < 0)          begin pend_next = 0;          bad = 1'b1; end
    if (pend_next > PEND_LIMIT) begin pend_next = PEND_LIMIT; bad = 1'b1; end
    if (reset) begin
      m_reads = 0; m_writes = 0; m_stalls = 0; m_lat = 0; m_pf = 0; m_pend = 0; m_err = 0;
    end else if (perf_clear) begin
      m_reads = 0; m_writes = 0; m_stalls = 0; m_lat = 0; m_pf = 0; m_err = 0;
      m_pend = pend_next;
    end else begin
      m_lat    = (m_lat + m_pend) & MASK;
      m_reads  = (m_reads + longint'(rd)) & MASK;
      m_writes = (m_writes + longint'(req && mem_req_rw)) & MASK;
      m_stalls = (m_stalls + longint'(mem_req_valid && !mem_req_ready)) & MASK;
      m_pf     = (m_pf + longint'(req && mem_req_prefetch)) & MASK;
      m_err    = m_err | bad;
      m_pend   = pend_next;
    end
  endtask

  task automatic cycle();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit rst, input bit clr, input bit rv, input bit rr, input bit rw,
                       input bit pf, input bit sv, input bit sr);
    reset = rst; perf_clear = clr;
    mem_req_valid = rv; mem_req_ready = rr; mem_req_rw = rw; mem_req_prefetch = pf;
    mem_rsp_valid = sv; mem_rsp_ready = sr;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic rd_req();  drive(0, 0, 1, 1, 0, 0, 0, 0); endtask
  task automatic rsp();     drive(0, 0, 0, 0, 0, 0, 1, 1); endtask
  task automatic do_reset(); drive(1, 0, 0, 0, 0, 0, 0, 0); endtask

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".reads"},    longint'(mem_reads), m_reads);
    chk({tag, ".writes"},   longint'(mem_writes), m_writes);
    chk({tag, ".stalls"},   longint'(mem_stalls), m_stalls);
    chk({tag, ".latency"},  longint'(mem_latency), m_lat);
    chk({tag, ".prefetch"}, longint'(dcache_prefetch_requests), m_pf);
    chk({tag, ".pending"},  longint'(pending_reads), longint'(m_pend));
    chk({tag, ".err"},      longint'(perf_err), longint'(m_err));
  endtask

  initial begin
    m_reads = 0; m_writes = 0; m_stalls = 0; m_lat = 0; m_pf = 0; m_pend = 0; m_err = 0;
    do_reset();
    do_reset();

    // Idle after reset
    idle(10);
    chk("idle.reads", longint'(mem_reads), 0);
    chk("idle.latency", longint'(mem_latency), 0);
    chk("idle.pending", longint'(pending_reads), 0);
    chk("idle.err", longint'(perf_err), 0);
    check_model("idle");

    // Single read at cycle 5, response at cycle 9
    do_reset();
    idle(5);
    rd_req();
    chk("single.pending_c6", longint'(pending_reads), 1);
    idle(3);
    chk("single.pending_c9", longint'(pending_reads), 1);
    rsp();
    chk("single.pending_c10", longint'(pending_reads), 0);
    chk("single.reads", longint'(mem_reads), 1);
    chk("single.latency", longint'(mem_latency), 4);
    chk("single.err", longint'(perf_err), 0);

    // Three back-to-back reads answered at cycles 10..12, then a read cleared mid-flight
    do_reset();
    rd_req(); rd_req(); rd_req();
    chk("b2b.peak_pending", longint'(pending_reads), 3);
    idle(7);
    rsp(); rsp(); rsp();
    chk("b2b.reads", longint'(mem_reads), 3);
    chk("b2b.latency", longint'(mem_latency), 30);
    chk("b2b.pending", longint'(pending_reads), 0);
    rd_req();
    chk("clr.pre_latency", longint'(mem_latency), 30);
    chk("clr.pre_pending", longint'(pending_reads), 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("clr.reads", longint'(mem_reads), 0);
    chk("clr.latency", longint'(mem_latency), 0);
    chk("clr.pending_kept", longint'(pending_reads), 1);
    chk("clr.err", longint'(perf_err), 0);
    idle(3);
    rsp();
    chk("clr.post_latency", longint'(mem_latency), 4);
    chk("clr.post_pending", longint'(pending_reads), 0);
    check_model("clr");

    // Write, prefetch read, then 4 stall cycles
    do_reset();
    drive(0, 0, 1, 1, 1, 0, 0, 0);
    drive(0, 0, 1, 1, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 0, 1, 0, 0, 0, 0, 0);
    chk("mix.writes", longint'(mem_writes), 1);
    chk("mix.reads", longint'(mem_reads), 1);
    chk("mix.prefetch", longint'(dcache_prefetch_requests), 1);
    chk("mix.stalls", longint'(mem_stalls), 4);
    rsp();
    check_model("mix");

    // Simultaneous issue/retire, then underflow, then clear of the sticky flag
    do_reset();
    rd_req(); rd_req();
    drive(0, 0, 1, 1, 0, 0, 1, 1);
    chk("simul.pending", longint'(pending_reads), 2);
    rsp(); rsp();
    chk("simul.err_clean", longint'(perf_err), 0);
    rsp();
    chk("under.pending", longint'(pending_reads), 0);
    chk("under.err", longint'(perf_err), 1);
    drive(0, 1, 0, 0, 0, 0, 0, 0);
    chk("under.err_cleared", longint'(perf_err), 0);

    // Overflow: one read past the tracker limit
    do_reset();
    for (int i = 0; i <= PEND_LIMIT; i++) rd_req();
    chk("over.pending", longint'(pending_reads), PEND_LIMIT);
    chk("over.err", longint'(perf_err), 1);
    chk("over.reads", longint'(mem_reads), PEND_LIMIT + 1);
    check_model("over");

    // Randomized traffic against the reference model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset            = ($urandom_range(0, 599) == 0);
      perf_clear       = ($urandom_range(0, 79) == 0);
      mem_req_valid    = ($urandom_range(0, 2) != 0);
      mem_req_ready    = ($urandom_range(0, 3) != 0);
      mem_req_rw       = ($urandom_range(0, 2) == 0);
      mem_req_prefetch = ($urandom_range(0, 4) == 0);
      mem_rsp_valid    = (m_pend > 0) ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 30) == 0);
      mem_rsp_ready    = ($urandom_range(0, 5) != 0);
      cycle();
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
